// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU sequencer: opcodes, FSM encoding and the opcode legality check.
package vec_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Element index counters and wrapping base+index address adders for the A, B and destination RAMs.
module vec_addr_gen
  import vec_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd_step,
  input  logic              wr_step,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_rd
);

  logic [ADDR_W-1:0] a_base_r;
  logic [ADDR_W-1:0] b_base_r;
  logic [ADDR_W-1:0] d_base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  rd_idx_r;
  logic [ADDR_W-1:0] wr_idx_r;

  // Latch bases on command start, then advance read/write indices independently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_base_r <= {ADDR_W{1'b0}};
      b_base_r <= {ADDR_W{1'b0}};
      d_base_r <= {ADDR_W{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      rd_idx_r <= {LEN_W{1'b0}};
      wr_idx_r <= {ADDR_W{1'b0}};
    end else if (start) begin
      a_base_r <= a_base;
      b_base_r <= b_base;
      d_base_r <= d_base;
      len_r    <= len;
      rd_idx_r <= {LEN_W{1'b0}};
      wr_idx_r <= {ADDR_W{1'b0}};
    end else begin
      if (rd_step) rd_idx_r <= rd_idx_r + LEN_W'(1);
      if (wr_step) wr_idx_r <= wr_idx_r + ADDR_W'(1);
    end
  end

  // Adders truncate to ADDR_W so addresses wrap naturally
  assign rd_a_addr = a_base_r + rd_idx_r[ADDR_W-1:0];
  assign rd_b_addr = b_base_r + rd_idx_r[ADDR_W-1:0];
  assign wr_addr   = d_base_r + wr_idx_r;
  assign last_rd   = (rd_idx_r == (len_r - LEN_W'(1)));

endmodule

// File: rtl/vec_alu_seq.sv
// Command-driven sequencer streaming operand RAM pairs through the external modular ALU into the destination RAM.
// Optional feature macro: VEC_SEQ_SCALAR_B_EN (broadcast scalar B operand).
module vec_alu_seq
  import vec_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_q,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  input  logic [ADDR_W-1:0] cmd_d_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_b_scalar,
  input  logic [DATA_W-1:0] cmd_scalar,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  input  logic [DATA_W-1:0] rd_a_data,
  input  logic [DATA_W-1:0] rd_b_data,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  output logic [DATA_W-1:0] alu_q,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              err
);

  state_t            state_r, state_s;
  logic              accept_s, go_s, last_rd_s;
  logic [2:0]        opcode_r;
  logic [DATA_W-1:0] q_r;
  logic              bad_r;
  logic              v1_r, v2_r, wr_en_r, done_r, err_r;
  logic [DATA_W-1:0] op_a_r, op_b_r, wr_data_r, operand_b_s;
  logic [ADDR_W-1:0] gen_b_addr_s;

  assign accept_s = cmd_valid && (state_r == ST_IDLE);
  assign go_s     = accept_s && (cmd_len != {LEN_W{1'b0}}) && is_legal_op(cmd_opcode);
  assign rd_en    = (state_r == ST_RUN);

  vec_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (go_s),
    .rd_step   (rd_en),
    .wr_step   (wr_en_r),
    .a_base    (cmd_a_base),
    .b_base    (cmd_b_base),
    .d_base    (cmd_d_base),
    .len       (cmd_len),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (gen_b_addr_s),
    .wr_addr   (wr_addr),
    .last_rd   (last_rd_s)
  );

`ifdef VEC_SEQ_SCALAR_B_EN
  logic              scalar_en_r;
  logic [DATA_W-1:0] scalar_r;

  // Capture the broadcast operand with the command
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scalar_en_r <= 1'b0;
      scalar_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      scalar_en_r <= cmd_b_scalar;
      scalar_r    <= cmd_scalar;
    end
  end

  assign operand_b_s = scalar_en_r ? scalar_r : rd_b_data;
  assign rd_b_addr   = scalar_en_r ? {ADDR_W{1'b0}} : gen_b_addr_s;
`else
  logic unused_scalar_s;
  assign unused_scalar_s = ^{cmd_b_scalar, cmd_scalar};
  assign operand_b_s     = rd_b_data;
  assign rd_b_addr       = gen_b_addr_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next state; DRAIN leaves once the last element has left the data stage
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = go_s ? ST_RUN : ST_DONE;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_rd_s) state_s = ST_DRAIN;
        else           state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!v1_r) state_s = ST_DONE;
        else       state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Command latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_r <= 3'd0;
      q_r      <= {DATA_W{1'b0}};
      bad_r    <= 1'b0;
    end else if (accept_s) begin
      opcode_r <= cmd_opcode;
      q_r      <= cmd_q;
      bad_r    <= !is_legal_op(cmd_opcode);
    end
  end

  // Read -> operand -> result pipeline plus completion flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      wr_en_r   <= 1'b0;
      op_a_r    <= {DATA_W{1'b0}};
      op_b_r    <= {DATA_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      v1_r    <= rd_en;
      v2_r    <= v1_r;
      wr_en_r <= v2_r;
      if (v1_r) begin
        op_a_r <= rd_a_data;
        op_b_r <= operand_b_s;
      end
      if (v2_r) wr_data_r <= alu_res;
      done_r <= (state_r == ST_DONE);
      err_r  <= (state_r == ST_DONE) && bad_r;
    end
  end

  assign cmd_ready  = (state_r == ST_IDLE);
  assign alu_opcode = opcode_r;
  assign alu_q      = q_r;
  assign alu_op_a   = op_a_r;
  assign alu_op_b   = op_b_r;
  assign wr_en      = wr_en_r;
  assign wr_data    = wr_data_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Randomized self-checking bench for vec_alu_seq with RAM/ALU models and an element-level reference model.
module tb_vec_alu_seq;

  localparam int DW = 64, AW = 10, LW = 11, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_b_scalar;
  logic [2:0]    cmd_opcode, alu_opcode;
  logic [DW-1:0] cmd_q, cmd_scalar, rd_a_data, rd_b_data;
  logic [AW-1:0] cmd_a_base, cmd_b_base, cmd_d_base, rd_a_addr, rd_b_addr, wr_addr;
  logic [LW-1:0] cmd_len;
  logic          rd_en, wr_en, done, err;
  logic [DW-1:0] alu_op_a, alu_op_b, alu_q, alu_res, wr_data;

  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];
  logic [DW-1:0] d_mem [DEPTH];
  logic [DW-1:0] d_exp [DEPTH];
  bit            d_set [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_q(cmd_q), .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .cmd_d_base(cmd_d_base), .cmd_len(cmd_len), .cmd_b_scalar(cmd_b_scalar), .cmd_scalar(cmd_scalar),
    .rd_en(rd_en), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data),
    .rd_b_data(rd_b_data), .alu_opcode(alu_opcode), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_q(alu_q), .alu_res(alu_res), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err)
  );

  // Modular arithmetic on wide integers; operands are assumed already reduced mod q
  function automatic logic [DW-1:0] mod_op(input logic [2:0] op, input logic [DW-1:0] a, b, q);
    logic [127:0] w;
    if (q == 64'd0) return 64'd0;
    case (op)
      3'd0:    w = {64'd0, a} + {64'd0, b};
      3'd1:    w = {64'd0, a} + {64'd0, q} - {64'd0, b};
      3'd2:    w = {64'd0, a} * {64'd0, b};
      default: w = 128'd0;
    endcase
    return w[63:0] == w[63:0] ? 64'(w % {64'd0, q}) : 64'd0;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Environment: combinational ALU and synchronous RAMs
  always_comb alu_res = mod_op(alu_opcode, alu_op_a, alu_op_b, alu_q);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_a_data <= a_mem[rd_a_addr];
      rd_b_data <= b_mem[rd_b_addr];
    end
  end

  always @(posedge clk) begin
    if (wr_en) d_mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command and check every read, write and the done pulse against the model
  task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] q, input logic [AW-1:0] ab, bb, db,
                         input logic [LW-1:0] len, input logic bs, input logic [DW-1:0] sc);
    bit            legal   = (op <= 3'd2);
    int            n       = (legal && len != 0) ? int'(len) : 0;
    int            done_k  = (n != 0) ? n + 4 : 2;
    int            rd_cnt  = 0;
    int            wr_cnt  = 0;
    bit            got_done = 1'b0;
    bit            use_sc  = 1'b0;
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] bv;
`ifdef VEC_SEQ_SCALAR_B_EN
    use_sc = bs;
`endif
    for (int i = 0; i < n; i++) begin
      bv = use_sc ? sc : b_mem[(int'(bb) + i) % DEPTH];
      exp_w.push_back(mod_op(op, a_mem[(int'(ab) + i) % DEPTH], bv, q));
      d_exp[(int'(db) + i) % DEPTH] = exp_w[i];
      d_set[(int'(db) + i) % DEPTH] = 1'b1;
    end
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_opcode = op; cmd_q = q; cmd_a_base = ab; cmd_b_base = bb; cmd_d_base = db;
    cmd_len = len; cmd_b_scalar = bs; cmd_scalar = sc; cmd_valid = 1'b1;
    for (int k = 1; k <= n + 12 && !got_done; k++) begin
      @(negedge clk);
      if (rd_en) begin
        chk("rd_cycle", 64'(k), 64'(rd_cnt + 1));
        chk("rd_a_addr", 64'(rd_a_addr), 64'((int'(ab) + rd_cnt) % DEPTH));
        chk("rd_b_addr", 64'(rd_b_addr), use_sc ? 64'd0 : 64'((int'(bb) + rd_cnt) % DEPTH));
        rd_cnt++;
      end
      if (wr_en) begin
        chk("wr_cycle", 64'(k), 64'(wr_cnt + 4));
        chk("wr_addr", 64'(wr_addr), 64'((int'(db) + wr_cnt) % DEPTH));
        chk("wr_data", wr_data, (wr_cnt < n) ? exp_w[wr_cnt] : ~wr_data);
        wr_cnt++;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_cycle", 64'(k), 64'(done_k));
        chk("err", 64'(err), 64'(!legal));
        chk("rd_count", 64'(rd_cnt), 64'(n));
        chk("wr_count", 64'(wr_cnt), 64'(n));
        chk("alu_opcode_hold", 64'(alu_opcode), 64'(op));
        chk("alu_q_hold", alu_q, q);
      end
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_opcode = 3'($urandom()); cmd_q = rnd64();
        cmd_a_base = AW'($urandom()); cmd_b_base = AW'($urandom()); cmd_d_base = AW'($urandom());
        cmd_len = LW'($urandom()); cmd_b_scalar = 1'($urandom()); cmd_scalar = rnd64();
      end
    end
    if (!got_done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Start a len=8 command, reset during T+3, and confirm it is aborted cleanly
  task automatic reset_mid_cmd();
    int stray = 0;
    @(negedge clk);
    cmd_opcode = 3'd0; cmd_q = 64'd1000; cmd_a_base = 10'd0; cmd_b_base = 10'd0;
    cmd_d_base = 10'd900; cmd_len = 11'd8; cmd_b_scalar = 1'b0; cmd_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
    chk("rst_mid_rd_en", 64'(rd_en), 64'd0);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    chk("rst_mid_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || wr_en || rd_en) stray++;
    end
    chk("rst_mid_quiet", 64'(stray), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q, sc;
    logic [2:0]    op;
    logic [LW-1:0] len;
    logic [AW-1:0] ab, bb, db;
    int            mism;
    for (int i = 0; i < DEPTH; i++) begin
      a_mem[i] = 64'd0; b_mem[i] = 64'd0; d_exp[i] = 64'd0; d_set[i] = 1'b0;
    end
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_q = 64'd0; cmd_a_base = 10'd0;
    cmd_b_base = 10'd0; cmd_d_base = 10'd0; cmd_len = 11'd0; cmd_b_scalar = 1'b0; cmd_scalar = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_alu_q", alu_q, 64'd0);
    chk("rst_alu_op_a", alu_op_a, 64'd0);
    chk("rst_rd_a_addr", 64'(rd_a_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst_n = 1'b1;

    // ADD mod 17 with wrap-around results
    a_mem[10] = 64'd1; a_mem[11] = 64'd2;  a_mem[12] = 64'd3;  a_mem[13] = 64'd16;
    b_mem[40] = 64'd1; b_mem[41] = 64'd5;  b_mem[42] = 64'd14; b_mem[43] = 64'd1;
    run_cmd(3'd0, 64'd17, 10'd10, 10'd40, 10'd20, 11'd4, 1'b0, 64'd0);
    chk("t1_d0", d_mem[20], 64'd2);
    chk("t1_d1", d_mem[21], 64'd7);
    chk("t1_d2", d_mem[22], 64'd0);
    chk("t1_d3", d_mem[23], 64'd0);

    // MULT 2^60 * 2^60 mod (2^61-1) = 2^59
    a_mem[100] = 64'h1000_0000_0000_0000; b_mem[200] = 64'h1000_0000_0000_0000;
    run_cmd(3'd2, 64'h1FFF_FFFF_FFFF_FFFF, 10'd100, 10'd200, 10'd300, 11'd1, 1'b0, 64'd0);
    chk("t2_d", d_mem[300], 64'h0800_0000_0000_0000);

    // Zero length, then illegal opcode
    run_cmd(3'd0, 64'd17, 10'd0, 10'd0, 10'd0, 11'd0, 1'b0, 64'd0);
    run_cmd(3'd5, 64'd17, 10'd0, 10'd0, 10'd0, 11'd4, 1'b0, 64'd0);

    // Address wrap on reads and writes
    a_mem[1022] = 64'd900; a_mem[1023] = 64'd5; a_mem[0] = 64'd999;
    b_mem[500] = 64'd901; b_mem[501] = 64'd4; b_mem[502] = 64'd0;
    run_cmd(3'd1, 64'd1000, 10'd1022, 10'd500, 10'd1023, 11'd3, 1'b0, 64'd0);

    reset_mid_cmd();
    run_cmd(3'd0, 64'd17, 10'd10, 10'd40, 10'd24, 11'd4, 1'b0, 64'd0);
    chk("post_rst_d1", d_mem[25], 64'd7);

`ifdef VEC_SEQ_SCALAR_B_EN
    a_mem[600] = 64'd3; a_mem[601] = 64'd10;
    run_cmd(3'd1, 64'd97, 10'd600, 10'd700, 10'd800, 11'd2, 1'b1, 64'd5);
    chk("t6_d0", d_mem[800], 64'd95);
    chk("t6_d1", d_mem[801], 64'd5);
`endif

    // Randomized commands
    for (int t = 0; t < 30; t++) begin
      q   = ($urandom_range(0, 1) == 0) ? (rnd64() | 64'd1) : 64'($urandom_range(2, 1000));
      op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      len = (t == 29) ? 11'd1030 : LW'($urandom_range(0, 40));
      ab  = AW'($urandom()); bb = AW'($urandom()); db = AW'($urandom());
      sc  = rnd64() % q;
      for (int i = 0; i < int'(len); i++) begin
        a_mem[(int'(ab) + i) % DEPTH] = rnd64() % q;
        b_mem[(int'(bb) + i) % DEPTH] = rnd64() % q;
      end
      run_cmd(op, q, ab, bb, db, len, 1'($urandom_range(0, 1)), sc);
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (d_set[i] && d_mem[i] !== d_exp[i]) mism++;
    end
    chk("dest_ram_image", 64'(mism), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
